// File: rtl/mem_sub_unit_arbiter_pkg.sv
// Shared definitions for the memory sub-unit arbiter.
// Holds the default sizing and the helper that derives the width of a
// requester (source) index from the number of requesters.
package mem_sub_unit_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ         = 2;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  // Width of a requester index: clog2(n), never narrower than one bit.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_sub_unit_arb_tracker.sv
// In-order tracker of outstanding reads: a small synchronous FIFO of source
// indices. One entry is pushed per accepted read and popped per response.
// A push and a pop in the same cycle are honoured at any occupancy,
// including full, leaving the count unchanged.
//   clk, rst  : clock, synchronous active-high reset
//   push      : enqueue push_idx
//   push_idx  : requester index of the accepted read
//   pop       : dequeue the head (ignored when empty)
//   full      : DEPTH entries held
//   empty     : no entries held
//   head      : requester index of the oldest outstanding read
module mem_sub_unit_arb_tracker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_idx,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    head     = mem_q[rd_ptr_q];
    do_pop   = pop & ~empty;
    // At full, the slot written is the one being retired this cycle.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_idx;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_sub_unit_arbiter.sv
// Round-robin arbiter sharing one memory sub-unit responder port between
// NUM_REQ requesters. Selection and the request mux are combinational; the
// source of every accepted read is queued so responses (strictly in order)
// are steered back to the requester that issued them.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/addr/re/we/be/data_in : per-requester request, slice i
//   req_ready         : request i accepted this cycle (at most one bit)
//   req_data_out      : read data, shared by all requesters
//   req_data_valid    : read response for requester i
//   mem_addr/re/we/be/data_in/new_request : request to the responder
//   mem_data_out/data_valid/ready          : responder return path
module mem_sub_unit_arbiter
  import mem_sub_unit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_re,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*4-1:0]  req_be,
  input  logic [NUM_REQ*32-1:0] req_data_in,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           req_data_out,
  output logic [NUM_REQ-1:0]    req_data_valid,
  output logic [31:0]           mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_data_in,
  output logic                  mem_new_request,
  input  logic [31:0]           mem_data_out,
  input  logic                  mem_data_valid,
  input  logic                  mem_ready
);

  localparam int unsigned SW = src_idx_w(NUM_REQ);

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] winner;
  logic [SW:0]   cand;
  logic          any_valid, win_re, can_issue, accept;
  logic          trk_push, trk_pop, trk_full, trk_empty;
  logic [SW-1:0] trk_head;

  // Priority rotate: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner    = rr_ptr_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (SW+1)'(i);
      if (cand >= (SW+1)'(NUM_REQ)) begin
        cand = cand - (SW+1)'(NUM_REQ);
      end
      if (!any_valid && req_valid[cand[SW-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    win_re    = req_re[winner];
    trk_pop   = mem_data_valid & ~rst;
    // A response retiring the head frees its slot in the same cycle, so a
    // read may still issue against a full tracker when one is returning.
    can_issue = mem_ready & ~rst & ~(trk_full & win_re & ~mem_data_valid);
    accept    = any_valid & can_issue;
    trk_push  = accept & win_re;

    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end

    mem_addr        = req_addr[32*winner +: 32];
    mem_re          = req_re[winner];
    mem_we          = req_we[winner];
    mem_be          = req_be[4*winner +: 4];
    mem_data_in     = req_data_in[32*winner +: 32];
    mem_new_request = accept;

    req_data_out   = mem_data_out;
    req_data_valid = '0;
    if (mem_data_valid && !trk_empty && !rst) begin
      req_data_valid[trk_head] = 1'b1;
    end

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (winner == SW'(NUM_REQ - 1)) ? '0 : winner + SW'(1);
    end
  end

  mem_sub_unit_arb_tracker #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (SW)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .push     (trk_push),
    .push_idx (winner),
    .pop      (trk_pop),
    .full     (trk_full),
    .empty    (trk_empty),
    .head     (trk_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (mem_data_valid) begin
        assert (!trk_empty)
          else $warning("mem_sub_unit_arbiter: response with no outstanding read, dropped");
      end
      if (any_valid) begin
        assert (!(win_re && mem_we))
          else $warning("mem_sub_unit_arbiter: request with both re and we, tracked as read");
      end
    end
  end

endmodule

// File: tb/tb_mem_sub_unit_arbiter.sv
module tb_mem_sub_unit_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_re, req_we, req_ready, req_data_valid;
  logic [N*32-1:0] req_addr, req_data_in;
  logic [N*4-1:0]  req_be;
  logic [31:0]     req_data_out, mem_addr, mem_data_in, mem_data_out;
  logic            mem_re, mem_we, mem_new_request, mem_data_valid, mem_ready;
  logic [3:0]      mem_be;

  always #5 clk = ~clk;

  mem_sub_unit_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_re(req_re), .req_we(req_we),
    .req_be(req_be), .req_data_in(req_data_in), .req_ready(req_ready),
    .req_data_out(req_data_out), .req_data_valid(req_data_valid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_data_in(mem_data_in), .mem_new_request(mem_new_request),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .mem_ready(mem_ready)
  );

  typedef struct { int src; logic [31:0] addr; } rsp_t;

  rsp_t        exp_q[$];   // responses the requesters should see, in order
  logic [31:0] pend_q[$];  // addresses of reads the responder still owes
  int          tests = 0;
  int          fails = 0;
  int          rr_m  = 0;

  bit          pend [N];
  logic [31:0] p_addr [N];
  logic [31:0] p_data [N];
  bit          p_re [N];
  bit          p_we [N];
  logic [3:0]  p_be [N];
  bit          g_rst, g_mem_ready, g_rsp_en, g_force_rsp;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input bit re, input bit we);
    pend[i]   = 1'b1;
    p_addr[i] = a;
    p_re[i]   = re;
    p_we[i]   = we;
    p_be[i]   = 4'($urandom);
    p_data[i] = $urandom;
  endtask

  // One clock: drive inputs, check the combinational request side against the
  // reference model, then advance the model to the following edge.
  task automatic step();
    int w;
    bit anyv, rsp, full_blk, can, acc;
    @(negedge clk);
    rst       = g_rst;
    mem_ready = g_mem_ready;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_addr[32*i +: 32]    = p_addr[i];
      req_re[i]               = p_re[i];
      req_we[i]               = p_we[i];
      req_be[4*i +: 4]        = p_be[i];
      req_data_in[32*i +: 32] = p_data[i];
    end
    rsp            = !g_rst && ((g_rsp_en && pend_q.size() > 0) || g_force_rsp);
    mem_data_valid = rsp;
    mem_data_out   = (pend_q.size() > 0) ? rdata(pend_q[0]) : 32'hDEAD_BEEF;
    #1;
    w    = rr_m;
    anyv = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr_m + k) % N;
      if (!anyv && pend[j]) begin
        anyv = 1'b1;
        w    = j;
      end
    end
    full_blk = (pend_q.size() == MAXO) && !rsp;
    can      = g_mem_ready && !g_rst && !(full_blk && p_re[w]);
    acc      = anyv && can;
    chk("req_ready", 32'(req_ready), acc ? (32'd1 << w) : 32'd0);
    chk("mem_new_request", 32'(mem_new_request), 32'(acc));
    if (!g_rst) begin
      chk("mem_addr", mem_addr, p_addr[w]);
      chk("mem_ctl", 32'({mem_re, mem_we, mem_be}), 32'({p_re[w], p_we[w], p_be[w]}));
      chk("mem_data_in", mem_data_in, p_data[w]);
    end
    if (g_rst) begin
      rr_m = 0;
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (rsp && pend_q.size() > 0) void'(pend_q.pop_front());
      if (acc) begin
        rr_m    = (w + 1) % N;
        pend[w] = 1'b0;
        if (p_re[w]) begin
          pend_q.push_back(p_addr[w]);
          exp_q.push_back('{w, p_addr[w]});
        end
      end
    end
  endtask

  task automatic drain();
    int c;
    g_rsp_en    = 1'b1;
    g_mem_ready = 1'b1;
    c = 0;
    while (c < 200 && (pend_q.size() > 0 || pend[0] || pend[1])) begin
      step();
      c++;
    end
    chk("drain_left", 32'(pend_q.size()) + 32'(pend[0]) + 32'(pend[1]), 32'd0);
  endtask

  // Response monitor: whenever a requester is handed read data, it must be
  // the oldest expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (req_data_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(req_data_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 32'(req_data_valid), 32'd1 << e.src);
          chk("rsp_data", req_data_out, rdata(e.addr));
        end
      end
    end
  end

  initial begin
    int prob [6] = '{80, 10, 50, 0, 90, 30};
    bit re;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_re = '0; req_we = '0;
    req_be = '0; req_data_in = '0; mem_data_out = '0; mem_data_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; p_re[i] = 1'b0;
      p_we[i] = 1'b0; p_be[i] = '0;
    end
    g_rst = 1'b1; g_mem_ready = 1'b1; g_rsp_en = 1'b0; g_force_rsp = 1'b0;

    // Requests held during reset must not be accepted.
    set_req(0, 32'h40, 1'b1, 1'b0);
    set_req(1, 32'h80, 1'b0, 1'b1);
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    g_rst   = 1'b0;

    // Single read from requester 1 and its response.
    set_req(1, 32'h100, 1'b1, 1'b0);
    step();
    chk("single_rd_ready", 32'(req_ready), 32'd2);
    chk("single_rd_addr", mem_addr, 32'h100);
    g_rsp_en = 1'b1;
    step();
    chk("single_rd_rsp", 32'(req_data_valid), 32'd2);
    g_rsp_en = 1'b0;

    // Contention: acceptances alternate and fill the tracker with 4 reads.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && k < 3) set_req(i, $urandom, 1'b1, 1'b0);
      step();
      chk("contend_order", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Tracker full: writes pass, reads wait unless a response retires one.
    set_req(1, 32'h200, 1'b0, 1'b1);
    step();
    chk("full_wr_ok", 32'(req_ready), 32'd2);
    set_req(0, 32'h300, 1'b1, 1'b0);
    step();
    chk("full_rd_block", 32'(req_ready), 32'd0);
    g_rsp_en = 1'b1;
    step();
    chk("full_pop_push", 32'(req_ready), 32'd1);
    g_rsp_en = 1'b0;
    set_req(1, 32'h400, 1'b1, 1'b0);
    step();
    chk("full_still_full", 32'(req_ready), 32'd0);

    // Responder not ready: nothing accepted, pointer holds.
    set_req(0, 32'h500, 1'b0, 1'b1);
    g_mem_ready = 1'b0;
    step();
    chk("stall_ready", 32'(req_ready), 32'd0);
    chk("stall_newreq", 32'(mem_new_request), 32'd0);
    g_mem_ready = 1'b1;
    g_rsp_en    = 1'b1;
    step();
    chk("stall_rr_kept", 32'(req_ready), 32'd2);
    drain();

    // Randomized traffic with varying response rates.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(99) < 60) begin
            re = 1'($urandom_range(1));
            set_req(i, $urandom, re, !re);
          end
        end
        g_mem_ready = ($urandom_range(99) < 85);
        g_rsp_en    = ($urandom_range(99) < prob[ph]);
        step();
      end
    end
    drain();

    // Ordering: reads from 0, 1, 0 then back-to-back responses.
    g_rsp_en = 1'b0;
    set_req(0, 32'h600, 1'b1, 1'b0); step();
    set_req(1, 32'h604, 1'b1, 1'b0); step();
    set_req(0, 32'h608, 1'b1, 1'b0); step();
    g_rsp_en = 1'b1;
    step(); chk("order_0", 32'(req_data_valid), 32'd1);
    step(); chk("order_1", 32'(req_data_valid), 32'd2);
    step(); chk("order_2", 32'(req_data_valid), 32'd1);

    // Reset with two reads outstanding; a later response is dropped.
    g_rsp_en = 1'b0;
    set_req(0, 32'h700, 1'b1, 1'b0); step();
    set_req(1, 32'h704, 1'b1, 1'b0); step();
    g_rst = 1'b1;
    step();
    g_rst       = 1'b0;
    g_force_rsp = 1'b1;
    step();
    chk("post_rst_rsp_dropped", 32'(req_data_valid), 32'd0);
    g_force_rsp = 1'b0;
    set_req(0, 32'h800, 1'b0, 1'b1);
    set_req(1, 32'h804, 1'b0, 1'b1);
    step();
    chk("post_rst_rr", 32'(req_ready), 32'd1);
    drain();

    #5;
    chk("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
